mac_cluster_sequencer: RTL and testbench
========================================

// Module: mac_cluster_sequencer
// PURPOSE
//  Host-side driver for one quad MAC cluster; the host never touches cset/cfg or the operands directly.
//  Assembles the wide cfg word from narrow host words, then pulses cset.
//  Streams N operand beats into the cluster, inserting zero operands on bubbles.
//  Waits out the pipeline latency, captures out0..out3 and returns them over a valid/ready result port.
// PARAMETERS
//  MAC_CONF_WIDTH  4    cfg mode bits {signed, mac/mul, size[1:0]}
//  MAC_MIN_WIDTH   8    per-lane operand width
//  MAC_ACC_WIDTH   32   per-block accumulator width
//  CMD_WIDTH       32   host command word width
//  CNT_WIDTH       16   beat-count width
//  PIPE_LAT        3    cluster cycles from operand drive to visible out* update
// PORTS
//  clk        in   1                       clock, all flops rising edge
//  rst_n      in   1                       asynchronous, active-low reset
//  cmd_valid  in   1                       host command word valid
//  cmd_ready  out  1                       sequencer accepts command word
//  cmd_data   in   CMD_WIDTH               cfg word chunk / beat count
//  op_valid   in   1                       operand beat valid
//  op_ready   out  1                       operand beat accepted
//  op_data    in   8*MAC_MIN_WIDTH         {B3,B2,B1,B0,A3,A2,A1,A0}, A0 in LSBs
//  res_valid  out  1                       captured result valid
//  res_ready  in   1                       host takes result
//  res_data   out  4*MAC_ACC_WIDTH         {out3,out2,out1,out0}
//  mac_en     out  1                       cluster enable
//  mac_cset   out  1                       cluster config strobe
//  mac_cfg    out  4*MAC_ACC_WIDTH+MAC_CONF_WIDTH  cluster cfg bus
//  mac_a      out  4*MAC_MIN_WIDTH         {A3..A0} to cluster
//  mac_b      out  4*MAC_MIN_WIDTH         {B3..B0} to cluster
//  mac_out    in   4*MAC_ACC_WIDTH         {out3..out0} from cluster
//  perf_stall out  CNT_WIDTH               bubble counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=LOAD, word index=0, mac_cfg=0, mac_cset=0, mac_en=0, mac_a=mac_b=0.
//  Reset also clears: res_valid=0, res_data=0, cmd_ready=1, op_ready=0, perf_stall=0.
//  Reset asserted mid-operation aborts immediately; no partial result is ever presented.
//  CFG_WORDS = ceil((4*MAC_ACC_WIDTH+MAC_CONF_WIDTH)/CMD_WIDTH); 5 at the defaults.
//  LOAD: cmd_ready=1. Each cmd handshake writes mac_cfg slice [idx*CMD_WIDTH +: CMD_WIDTH].
//   Slices are filled LSB first; excess bits of the last slice are dropped.
//   The handshake after CFG_WORDS cfg words latches beat count N=cmd_data[CNT_WIDTH-1:0] and moves to CSET.
//  CSET: exactly one cycle; mac_cset=1, mac_en=1, mac_a=mac_b=0, cmd_ready=0.
//   Next state is STREAM; if N==0 it goes straight to DRAIN.
//  STREAM: op_ready=1; a beat is accepted when op_valid&op_ready.
//   Accepted beat: mac_a/mac_b are registered from op_data the next cycle.
//   No beat accepted: zeros are registered instead, adding 0 to each accumulator.
//   mac_en=1 throughout. Remaining count decrements per beat; the beat that reaches 0 moves to DRAIN, op_ready=0.
//  DRAIN: PIPE_LAT-cycle down-counter; op_ready=0, zero operands are driven.
//   On expiry, mac_out is captured into res_data, res_valid=1, state=RESULT.
//   Capture is exactly PIPE_LAT cycles after the last beat reached mac_a/mac_b, so mul-only mode returns the last product.
//  RESULT: res_data is held stable while res_valid&!res_ready.
//   Handshake -> res_valid=0, index=0, state=LOAD; the cluster cfg stays latched.
//  N==0: the result equals the initial accumulator values loaded by cset.
//  cmd_valid outside LOAD and op_valid outside STREAM are ignored (ready low, no side effects).
//  N=2^CNT_WIDTH-1 is legal; the count never wraps.
// CONFIGURATION
//  MAC_SEQ_PERF_EN defined: perf_stall counts STREAM cycles with op_valid=0.
//   It clears on entry to CSET and saturates at all-ones.
//  MAC_SEQ_PERF_EN undefined: perf_stall is tied to 0 and no counter logic is built.
// STRUCTURE
//  mac_const.vh: state encodings LOAD/CSET/STREAM/DRAIN/RESULT, CFG_WORDS computation, default PIPE_LAT.
//  Sub-module mac_cfg_assembler: word index counter + slice writes into mac_cfg; outputs cfg_done.
//  The top level keeps the FSM, beat/drain counters, operand mux, result capture and perf counter.
// TESTING
//  1) Unsigned MAC single mode, init 0, N=4 beats each with A0..3=2,B0..3=3 -> out0..3=24.
//  2) Signed MAC, init out0=100, N=1, A0=-5 (0xFB), B0=7 -> out0=65; res_data stable across 3 res_ready=0 cycles.
//  3) N=3 with op_valid gated 1,0,1,0,1 -> same sums as gapless; perf_stall=2 with MAC_SEQ_PERF_EN, 0 without.
//  4) Mul mode, 3 beats ending A0=9,B0=9 -> out0=81; N=0 with init out2=0x1234 -> res out2=0x1234.
//  5) rst_n low during STREAM beat 2 -> next cycle all outputs at reset values, state LOAD; a fresh job completes correctly.
//  6) cmd_valid during STREAM/RESULT and op_valid during LOAD -> no handshake; mac_cfg and count unchanged.

Source files
------------

// File: rtl/mac_cluster_sequencer_pkg.sv
// rtl/mac_cluster_sequencer_pkg.sv - shared states, defaults and cfg-word sizing for the MAC cluster sequencer
package mac_cluster_sequencer_pkg;

    localparam int DEF_CONF_WIDTH = 4;
    localparam int DEF_MIN_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_CMD_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_PIPE_LAT   = 3;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_CSET   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } seq_state_t;

    // Number of host words needed to cover the whole cfg bus, rounding up.
    function automatic int cfg_words(input int cfg_w, input int cmd_w);
        return (cfg_w + cmd_w - 1) / cmd_w;
    endfunction

endpackage

// File: rtl/mac_cluster_sequencer_cfg_assembler.sv
// rtl/mac_cluster_sequencer_cfg_assembler.sv - builds the wide cluster cfg word from narrow host words
module mac_cfg_assembler
    import mac_cluster_sequencer_pkg::*;
#(
    parameter int CFG_W = 132,
    parameter int CMD_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic             clr_i,
    input  logic [CMD_W-1:0] wr_data_i,
    output logic [CFG_W-1:0] cfg_o,
    output logic             done_o
);

    localparam int WORDS = cfg_words(CFG_W, CMD_W);
    localparam int IDX_W = $clog2(WORDS + 1);

    logic [IDX_W-1:0] idx_q;
    logic [CFG_W-1:0] cfg_q;

    assign done_o = (idx_q == IDX_W'(WORDS));
    assign cfg_o  = cfg_q;

    // Bits of the last word that fall past the cfg bus have no destination and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            cfg_q <= '0;
        end else if (clr_i) begin
            idx_q <= '0;
        end else if (wr_en_i && !done_o) begin
            for (int i = 0; i < CFG_W; i++) begin
                if ((i / CMD_W) == int'(idx_q)) begin
                    cfg_q[i] <= wr_data_i[i % CMD_W];
                end
            end
            idx_q <= idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/mac_cluster_sequencer.sv
// rtl/mac_cluster_sequencer.sv - host-side job sequencer for a quad MAC cluster; MAC_SEQ_PERF_EN enables the bubble counter
module mac_cluster_sequencer
    import mac_cluster_sequencer_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = DEF_CONF_WIDTH,
    parameter int MAC_MIN_WIDTH  = DEF_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CMD_WIDTH      = DEF_CMD_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int PIPE_LAT       = DEF_PIPE_LAT
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [CMD_WIDTH-1:0]                    cmd_data,
    input  logic                                    op_valid,
    output logic                                    op_ready,
    input  logic [8*MAC_MIN_WIDTH-1:0]              op_data,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [4*MAC_ACC_WIDTH-1:0]              res_data,
    output logic                                    mac_en,
    output logic                                    mac_cset,
    output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
    output logic [4*MAC_MIN_WIDTH-1:0]              mac_a,
    output logic [4*MAC_MIN_WIDTH-1:0]              mac_b,
    input  logic [4*MAC_ACC_WIDTH-1:0]              mac_out,
    output logic [CNT_WIDTH-1:0]                    perf_stall
);

    localparam int CFG_W = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH;
    localparam int LN_W  = 4*MAC_MIN_WIDTH;
    localparam int DRN_W = $clog2(PIPE_LAT + 1);

    seq_state_t               state_q;
    logic [CNT_WIDTH-1:0]     cnt_q;
    logic [DRN_W-1:0]         drain_q;
    logic                     cmd_ready_q;
    logic                     op_ready_q;
    logic                     res_valid_q;
    logic [4*MAC_ACC_WIDTH-1:0] res_data_q;
    logic                     mac_en_q;
    logic                     mac_cset_q;
    logic [LN_W-1:0]          mac_a_q;
    logic [LN_W-1:0]          mac_b_q;

    logic cmd_fire;
    logic op_fire;
    logic res_fire;
    logic cfg_done;
    logic cset_entry;

    assign cmd_fire   = cmd_valid && cmd_ready_q;
    assign op_fire    = op_valid && op_ready_q;
    assign res_fire   = res_valid_q && res_ready;
    assign cset_entry = (state_q == ST_LOAD) && cmd_fire && cfg_done;

    mac_cfg_assembler #(
        .CFG_W(CFG_W),
        .CMD_W(CMD_WIDTH)
    ) u_cfg_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (cmd_fire),
        .clr_i    (res_fire),
        .wr_data_i(cmd_data),
        .cfg_o    (mac_cfg),
        .done_o   (cfg_done)
    );

    // The last beat shows on mac_a/mac_b one edge after acceptance, so the drain
    // counter starts at PIPE_LAT and captures on the edge after it hits zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            drain_q     <= '0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            mac_en_q    <= 1'b0;
            mac_cset_q  <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (cset_entry) begin
                        cnt_q       <= cmd_data[CNT_WIDTH-1:0];
                        cmd_ready_q <= 1'b0;
                        mac_cset_q  <= 1'b1;
                        mac_en_q    <= 1'b1;
                        mac_a_q     <= '0;
                        mac_b_q     <= '0;
                        state_q     <= ST_CSET;
                    end
                end
                ST_CSET: begin
                    mac_cset_q <= 1'b0;
                    if (cnt_q == '0) begin
                        drain_q <= DRN_W'(PIPE_LAT);
                        state_q <= ST_DRAIN;
                    end else begin
                        op_ready_q <= 1'b1;
                        state_q    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (op_fire) begin
                        mac_a_q <= op_data[LN_W-1:0];
                        mac_b_q <= op_data[2*LN_W-1:LN_W];
                        cnt_q   <= cnt_q - 1'b1;
                        if (cnt_q == CNT_WIDTH'(1)) begin
                            op_ready_q <= 1'b0;
                            drain_q    <= DRN_W'(PIPE_LAT);
                            state_q    <= ST_DRAIN;
                        end
                    end else begin
                        mac_a_q <= '0;
                        mac_b_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    mac_a_q <= '0;
                    mac_b_q <= '0;
                    if (drain_q == '0) begin
                        res_data_q  <= mac_out;
                        res_valid_q <= 1'b1;
                        mac_en_q    <= 1'b0;
                        state_q     <= ST_RESULT;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_fire) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign mac_en    = mac_en_q;
    assign mac_cset  = mac_cset_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;

`ifdef MAC_SEQ_PERF_EN
    logic [CNT_WIDTH-1:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (cset_entry) begin
            perf_q <= '0;
        end else if ((state_q == ST_STREAM) && !op_valid && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_stall = perf_q;
`else
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mac_cluster_sequencer.sv
// tb/tb_mac_cluster_sequencer.sv - directed self-checking bench with a cluster stub and a job-level result model
module tb_mac_cluster_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [31:0]  cmd_data = '0;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [63:0]  op_data = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [127:0] res_data;
    logic         mac_en;
    logic         mac_cset;
    logic [131:0] mac_cfg;
    logic [31:0]  mac_a;
    logic [31:0]  mac_b;
    logic [127:0] mac_out;
    logic [15:0]  perf_stall;

    int checks = 0;
    int failures = 0;

`ifdef MAC_SEQ_PERF_EN
    localparam logic [15:0] EXP_STALL = 16'd2;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    always #5 clk = ~clk;

    mac_cluster_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_data   (op_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .mac_en    (mac_en),
        .mac_cset  (mac_cset),
        .mac_cfg   (mac_cfg),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_out   (mac_out),
        .perf_stall(perf_stall)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Lane product with 8-bit operands; signed mode sign-extends both.
    function automatic logic [31:0] lane_prod(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        logic [31:0] xa;
        logic [31:0] xb;
        xa = sgn ? {{24{a[7]}}, a} : {24'b0, a};
        xb = sgn ? {{24{b[7]}}, b} : {24'b0, b};
        return xa * xb;
    endfunction

    // Job-level expectation: start from the cset init values, then each beat
    // either accumulates (mac) or replaces (mul) the lane value.
    function automatic logic [127:0] model_res(input logic [131:0] cfg, input logic [63:0] beats[$]);
        logic [127:0] r;
        logic [31:0]  p;
        r = cfg[127:0];
        foreach (beats[k]) begin
            for (int i = 0; i < 4; i++) begin
                p = lane_prod(cfg[131], beats[k][8*i +: 8], beats[k][32+8*i +: 8]);
                r[32*i +: 32] = cfg[130] ? r[32*i +: 32] + p : p;
            end
        end
        return r;
    endfunction

    // Cluster stub: operands present in cycle k become visible on mac_out in cycle k+3.
    typedef struct packed {
        logic         en;
        logic         cset;
        logic [131:0] cfg;
        logic [31:0]  a;
        logic [31:0]  b;
    } stg_t;

    stg_t s0 = '0;
    stg_t s1 = '0;
    logic [127:0] stub_out = '0;
    assign mac_out = stub_out;

    always @(posedge clk) begin
        s0 <= {mac_en, mac_cset, mac_cfg, mac_a, mac_b};
        s1 <= s0;
        if (s1.en) begin
            if (s1.cset) begin
                stub_out <= s1.cfg[127:0];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    stub_out[32*i +: 32] <= s1.cfg[130]
                        ? stub_out[32*i +: 32] + lane_prod(s1.cfg[131], s1.a[8*i +: 8], s1.b[8*i +: 8])
                        : lane_prod(s1.cfg[131], s1.a[8*i +: 8], s1.b[8*i +: 8]);
                end
            end
        end
    end

    // Operand expectation: an accepted beat appears next cycle, anything else is zero.
    logic [31:0]  exp_a;
    logic [31:0]  exp_b;
    logic [127:0] exp_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_a <= '0;
            exp_b <= '0;
        end else begin
            exp_a <= (op_valid && op_ready) ? op_data[31:0]  : 32'd0;
            exp_b <= (op_valid && op_ready) ? op_data[63:32] : 32'd0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("mac_ab", 160'({mac_a, mac_b}), 160'({exp_a, exp_b}));
            if (res_valid) check("res_data", 160'(res_data), 160'(exp_res));
        end
    end

    function automatic logic [63:0] beat_all(input logic [7:0] a, input logic [7:0] b);
        return {b, b, b, b, a, a, a, a};
    endfunction

    function automatic logic [63:0] beat0(input logic [7:0] a, input logic [7:0] b);
        return {24'b0, b, 24'b0, a};
    endfunction

    task automatic send_cmd(input logic [31:0] d);
        int g;
        g = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (!cmd_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 160'(0), 160'(1));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send_cfg(input logic [131:0] cfg, input logic [15:0] n);
        logic [159:0] w;
        w = {28'hDEADBEE, cfg};
        for (int i = 0; i < 5; i++) send_cmd(w[32*i +: 32]);
        send_cmd({16'hA5A5, n});
    endtask

    task automatic stream(input logic [63:0] beats[$], input bit gaps);
        int  k;
        int  g;
        bit  v;
        k = 0;
        g = 0;
        v = 1'b1;
        @(negedge clk);
        while (!op_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!op_ready) check("op_ready_timeout", 160'(0), 160'(1));
        while (k < beats.size() && g < 200) begin
            op_valid = v;
            op_data  = beats[k];
            @(posedge clk);
            if (v) k++;
            @(negedge clk);
            if (gaps) v = ~v;
            g++;
        end
        op_valid = 1'b0;
        op_data  = '0;
    endtask

    task automatic run_job(input logic [131:0] cfg, input logic [63:0] beats[$], input bit gaps,
                           input bit junk, input int hold, output logic [127:0] got);
        int g;
        exp_res = model_res(cfg, beats);
        if (junk) begin
            op_valid = 1'b1;
            op_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        send_cfg(cfg, 16'(beats.size()));
        if (junk) begin
            check("op_ready_in_load", 160'(op_ready), 160'(0));
            cmd_valid = 1'b1;
            cmd_data  = 32'hFFFF_FFFF;
        end
        if (beats.size() > 0) stream(beats, gaps);
        op_valid = 1'b0;
        g = 0;
        while (!res_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!res_valid) check("res_valid_timeout", 160'(0), 160'(1));
        if (junk) check("cmd_ready_in_result", 160'(cmd_ready), 160'(0));
        repeat (hold) @(negedge clk);
        got = res_data;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        check("res_valid_after_hs", 160'(res_valid), 160'(0));
        check("cmd_ready_after_hs", 160'(cmd_ready), 160'(1));
        check("mac_cfg_latched", 160'(mac_cfg), 160'(cfg));
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_ctl"}, 160'({cmd_ready, op_ready, res_valid, mac_cset, mac_en}), 160'(5'b10000));
        check({tag, "_res"}, 160'(res_data), 160'(0));
        check({tag, "_cfg"}, 160'(mac_cfg), 160'(0));
        check({tag, "_ab"},  160'({mac_a, mac_b}), 160'(0));
        check({tag, "_perf"}, 160'(perf_stall), 160'(0));
    endtask

    logic [63:0]  bq[$];
    logic [127:0] got;
    logic [131:0] cfg_v;
    int           g;

    initial begin
        #12;
        reset_check("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1) unsigned MAC, 4 beats of 2*3 on every lane
        cfg_v = {4'b0100, 128'd0};
        bq = {};
        repeat (4) bq.push_back(beat_all(8'd2, 8'd3));
        check("model_t1", 160'(model_res(cfg_v, bq)), 160'({4{32'd24}}));
        run_job(cfg_v, bq, 1'b0, 1'b0, 0, got);
        check("t1_res", 160'(got), 160'({4{32'd24}}));
        check("t1_perf", 160'(perf_stall), 160'(0));

        // 2) signed MAC, init out0=100, -5*7; result held 3 cycles; stray cmd/op traffic
        cfg_v = {4'b1100, 96'd0, 32'd100};
        bq = {};
        bq.push_back(beat0(8'hFB, 8'd7));
        check("model_t2", 160'(model_res(cfg_v, bq)), 160'({96'd0, 32'd65}));
        run_job(cfg_v, bq, 1'b0, 1'b1, 3, got);
        check("t2_res", 160'(got), 160'({96'd0, 32'd65}));

        // 3) bubbles between beats do not change the sums
        cfg_v = {4'b0100, 128'd0};
        bq = {};
        bq.push_back(beat_all(8'd1, 8'd2));
        bq.push_back(beat_all(8'd3, 8'd4));
        bq.push_back(beat_all(8'd5, 8'd6));
        check("model_t3", 160'(model_res(cfg_v, bq)), 160'({4{32'd44}}));
        run_job(cfg_v, bq, 1'b1, 1'b0, 0, got);
        check("t3_res", 160'(got), 160'({4{32'd44}}));
        check("t3_perf", 160'(perf_stall), 160'(EXP_STALL));

        // 4a) mul mode returns the last product only
        cfg_v = {4'b0000, 128'd0};
        bq = {};
        bq.push_back(beat0(8'd2, 8'd3));
        bq.push_back(beat0(8'd4, 8'd5));
        bq.push_back(beat0(8'd9, 8'd9));
        check("model_t4a", 160'(model_res(cfg_v, bq)), 160'({96'd0, 32'd81}));
        run_job(cfg_v, bq, 1'b0, 1'b0, 0, got);
        check("t4a_res", 160'(got), 160'({96'd0, 32'd81}));

        // 4b) zero beats returns the cset init values
        cfg_v = {4'b0100, 32'd0, 32'h1234, 32'd0, 32'd0};
        bq = {};
        run_job(cfg_v, bq, 1'b0, 1'b0, 0, got);
        check("t4b_res", 160'(got), 160'({32'd0, 32'h1234, 64'd0}));

        // 5) reset during the second beat, then a fresh job
        cfg_v = {4'b0100, 128'd0};
        exp_res = '0;
        send_cfg(cfg_v, 16'd4);
        @(negedge clk);
        g = 0;
        while (!op_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!op_ready) check("t5_op_ready_timeout", 160'(0), 160'(1));
        op_valid = 1'b1;
        op_data  = beat_all(8'd7, 8'd7);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        op_valid = 1'b0;
        #1 reset_check("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bq = {};
        repeat (4) bq.push_back(beat_all(8'd2, 8'd3));
        run_job(cfg_v, bq, 1'b0, 1'b0, 0, got);
        check("t5_res", 160'(got), 160'({4{32'd24}}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
